// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision normalise/round/pack path.
// Holds the IEEE-754 field layout, the bit positions inside the extended
// mantissa and the payload carried between pipeline stages.
package fp_pkg;

   // IEEE-754 single-precision exponent constants
   localparam int EXP_BIAS   = 127;
   localparam int EXP_MAX    = 255;

   // Bit positions inside the 28-bit extended mantissa
   localparam int CARRY_BIT  = 27;
   localparam int HIDDEN_BIT = 26;
   localparam int LSB_BIT    = 3;
   localparam int G_BIT      = 2;
   localparam int R_BIT      = 1;
   localparam int S_BIT      = 0;

   // Internal widths: the intermediate exponent carries two extra bits so
   // that carry increments and large normalising shifts never wrap.
   localparam int EXP_I_W    = 10;
   localparam int MANT_X_W   = 28;
   localparam int LZ_W       = 5;

   localparam logic signed [EXP_I_W-1:0] EXP_MAX_I = 10'sd255;
   localparam logic signed [EXP_I_W-1:0] EXP_MIN_I = 10'sd1;

   // Packed IEEE-754 single
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   // Payload leaving the detect stage
   typedef struct packed {
      logic                sign;
      logic [EXP_I_W-1:0]  exp_i;
      logic [MANT_X_W-1:0] mant;
      logic [LZ_W-1:0]     lz;
      logic                zero;
      logic                uf;
   } fp_payload_t;

   // Payload leaving the normalise stage; the shift amount is consumed
   typedef struct packed {
      logic                sign;
      logic [EXP_I_W-1:0]  exp_i;
      logic [MANT_X_W-1:0] mant;
      logic                zero;
      logic                uf;
   } fp_norm_t;

   // True when an intermediate exponent no longer fits a finite normal
   function automatic logic isExpOverflow(input logic [EXP_I_W-1:0] e);
      return $signed(e) >= EXP_MAX_I;
   endfunction

   // True when an intermediate exponent falls into the denormal range
   function automatic logic isExpUnderflow(input logic [EXP_I_W-1:0] e);
      return $signed(e) < EXP_MIN_I;
   endfunction

endpackage

// File: rtl/fp_norm_round_lzc28.sv
// Combinational leading-zero counter over bits [26:0] of an extended
// mantissa. Counts from bit 26 downward; an all-zero input reports 27
// with the zero flag set. Shared with the multiplier path.
module lzc28
   import fp_pkg::*;
(
   input  logic [26:0]     bits_i,
   output logic [LZ_W-1:0] lz_o,
   output logic            zero_o
);

   // Scan upward so the highest set bit is the last one to write the count
   always_comb begin
      lz_o   = 5'd27;
      zero_o = 1'b1;
      for (int i = 0; i <= 26; i++) begin
         if (bits_i[i]) begin
            lz_o   = 5'(26 - i);
            zero_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fp_norm_round.sv
// Post-arithmetic normalise / round-to-nearest-even / pack stage for
// single precision. Three pipeline registers (detect, normalise, output)
// advance together whenever the output slot is empty or being drained.
module fp_norm_round
   import fp_pkg::*;
#(
   parameter int EXP_W    = 8,
   parameter int MANT_W   = 28,
   parameter bit ROUND_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [MANT_W-1:0] in_mant,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result,
   output logic              out_of,
   output logic              out_uf
);

   logic            advance;

   logic [LZ_W-1:0] lzCount;
   logic            lzZero;

   fp_payload_t     s1_d;
   fp_payload_t     s1_q;
   logic            valid1_q;

   fp_norm_t        s2_d;
   fp_norm_t        s2_q;
   logic            valid2_q;

   logic            rndUp;
   logic [24:0]     mantSum;
   logic [22:0]     fracR;
   logic [EXP_I_W-1:0] expR;
   fp32_t           pack;
   logic [31:0]     result_d;
   logic            of_d;
   logic            uf_d;

   logic            out_valid_q;
   logic [31:0]     out_result_q;
   logic            out_of_q;
   logic            out_uf_q;

   // The whole pipe moves as one; it only stalls when a finished result
   // is sitting at the output and nobody downstream is taking it.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   lzc28 u_lzc (
      .bits_i (in_mant[HIDDEN_BIT:0]),
      .lz_o   (lzCount),
      .zero_o (lzZero)
   );

   // Detect: fold a carry-out back into the hidden position (keeping the
   // dropped bit sticky), otherwise record how far the leading one sits
   // below the hidden position. The exponent is widened before any math.
   always_comb begin
      s1_d       = '0;
      s1_d.sign  = in_sign;
      s1_d.exp_i = {2'b00, in_exp};
      s1_d.mant  = in_mant;
      s1_d.lz    = lzCount;
      s1_d.zero  = lzZero && !in_mant[CARRY_BIT];
      s1_d.uf    = 1'b0;
      if (in_mant[CARRY_BIT]) begin
         s1_d.mant        = {1'b0, in_mant[MANT_W-1:1]};
         s1_d.mant[S_BIT] = in_mant[1] | in_mant[0];
         s1_d.exp_i       = {2'b00, in_exp} + 10'd1;
         s1_d.lz          = '0;
      end
   end

   // Normalise: bring the leading one up to the hidden position and charge
   // the shift to the exponent. Anything that lands below exponent 1 can
   // not be represented as a normal and is marked for flushing.
   always_comb begin
      s2_d       = '0;
      s2_d.sign  = s1_q.sign;
      s2_d.zero  = s1_q.zero;
      s2_d.mant  = s1_q.mant << s1_q.lz;
      s2_d.exp_i = s1_q.exp_i - {5'b00000, s1_q.lz};
      s2_d.uf    = s1_q.uf || (!s1_q.zero && isExpUnderflow(s2_d.exp_i));
   end

   // Round and pack: nearest-even increment at the fraction LSB, fold a
   // rounding carry back into the exponent, then pick zero / flushed zero /
   // infinity / finite packing in that priority so the flags stay exclusive.
   always_comb begin
      rndUp    = ROUND_EN && s2_q.mant[G_BIT] &&
                 (s2_q.mant[R_BIT] || s2_q.mant[S_BIT] || s2_q.mant[LSB_BIT]);
      mantSum  = s2_q.mant[CARRY_BIT:LSB_BIT] + 25'(rndUp);
      fracR    = mantSum[22:0];
      expR     = s2_q.exp_i;
      if (mantSum[24]) begin
         fracR = mantSum[23:1];
         expR  = s2_q.exp_i + 10'd1;
      end
      pack      = '0;
      pack.sign = s2_q.sign;
      of_d      = 1'b0;
      uf_d      = 1'b0;
      if (s2_q.zero) begin
         pack.exp  = '0;
         pack.frac = '0;
      end else if (s2_q.uf) begin
         pack.exp  = '0;
         pack.frac = '0;
         uf_d      = 1'b1;
      end else if (isExpOverflow(s2_q.exp_i) || isExpOverflow(expR)) begin
         pack.exp  = 8'hFF;
         pack.frac = '0;
         of_d      = 1'b1;
      end else begin
         pack.exp  = expR[7:0];
         pack.frac = fracR;
      end
      result_d = pack;
   end

   // Pipeline registers: reset clears every valid and the visible output;
   // a stall freezes all three stages so the presented result holds still.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid1_q     <= 1'b0;
         s1_q         <= '0;
         valid2_q     <= 1'b0;
         s2_q         <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_of_q     <= 1'b0;
         out_uf_q     <= 1'b0;
      end else if (advance) begin
         valid1_q     <= in_valid;
         s1_q         <= s1_d;
         valid2_q     <= valid1_q;
         s2_q         <= s2_d;
         out_valid_q  <= valid2_q;
         out_result_q <= valid2_q ? result_d : 32'h0;
         out_of_q     <= valid2_q && of_d;
         out_uf_q     <= valid2_q && uf_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_of     = out_of_q;
   assign out_uf     = out_uf_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round. A negedge monitor pushes a
// reference result for every accepted beat and pops/compares on every
// output handshake; the main block walks through directed steps.
module tb_fp_norm_round;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [27:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_of;
   logic        out_uf;

   int total = 0;
   int bad   = 0;
   logic [33:0] sb[$];

   fp_norm_round #(.EXP_W(8), .MANT_W(28), .ROUND_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mant    (in_mant),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_of     (out_of),
      .out_uf     (out_uf)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {of, uf, result} computed with plain integer arithmetic
   function automatic logic [33:0] refModel(input logic s, input logic [7:0] e8,
                                            input logic [27:0] m);
      int          e;
      logic [27:0] mm;
      logic [24:0] keep;
      logic [2:0]  rem;
      e  = int'(e8);
      mm = m;
      if (mm == 28'h0) return {2'b00, s, 31'h0};
      if (mm[27]) begin
         mm = {1'b0, mm[27:1]} | {27'h0, m[0]};
         e++;
      end
      while (!mm[26]) begin
         mm = mm << 1;
         e--;
      end
      if (e < 1) return {2'b01, s, 31'h0};
      keep = {1'b0, mm[26:3]};
      rem  = mm[2:0];
      if (rem > 3'd4 || (rem == 3'd4 && keep[0])) keep++;
      if (keep[24]) begin
         keep = keep >> 1;
         e++;
      end
      if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
      return {2'b00, s, e[7:0], keep[22:0]};
   endfunction

   // Single comparison point shared by every check in the bench
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one beat and hold it until it is accepted (bounded wait).
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic applyStimulus(input logic s, input logic [7:0] e,
                                input logic [27:0] m, input bit randReady);
      bit accepted;
      accepted = 1'b0;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      in_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         accepted = (in_ready === 1'b1);
         @(posedge clk);
         #1;
         if (randReady) out_ready = 1'($urandom_range(0, 1));
         if (accepted) break;
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
   endtask

   // Wait until every expected result has come out (bounded wait)
   task automatic drain();
      out_ready = 1'b1;
      for (int n = 0; n < 100; n++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #1;
      end
      checkOutput("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Scoreboard monitor: compares at the output handshake and records the
   // expectation at the input handshake; a reset discards everything queued.
   always @(negedge clk) begin
      logic [33:0] expv;
      if (rst === 1'b1) begin
         sb.delete();
      end else begin
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_out", 64'd1, 64'd0);
            end else begin
               expv = sb.pop_front();
               checkOutput("result", 64'({out_of, out_uf, out_result}), 64'(expv));
            end
         end
         if (in_valid === 1'b1 && in_ready === 1'b1)
            sb.push_back(refModel(in_sign, in_exp, in_mant));
      end
   end

   initial begin
      int          lat;
      logic [33:0] firstExp;
      logic [27:0] rm;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 8'h0;
      in_mant   = 28'h0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_result", 64'(out_result), 64'd0);
      checkOutput("rst_flags", 64'({out_of, out_uf}), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

      $display("[TB] latency check");
      in_sign  = 1'b0;
      in_exp   = 8'd127;
      in_mant  = 28'h1 << 26;
      in_valid = 1'b1;
      lat      = 0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat++;
         if (out_valid === 1'b1) break;
      end
      checkOutput("latency", 64'(lat), 64'd3);
      checkOutput("pass_through", 64'({out_of, out_uf, out_result}), {30'h0, 2'b00, 32'h3F800000});
      drain();

      $display("[TB] directed vectors");
      applyStimulus(1'b0, 8'd127, 28'hC000000, 1'b0);
      applyStimulus(1'b0, 8'd127, 28'h1 << 23, 1'b0);
      applyStimulus(1'b0, 8'd127, (28'h1 << 26) | 28'h4, 1'b0);
      applyStimulus(1'b0, 8'd127, (28'h1 << 26) | 28'h8 | 28'h4, 1'b0);
      applyStimulus(1'b0, 8'd254, 28'hC000000, 1'b0);
      applyStimulus(1'b1, 8'd2, 28'h1 << 20, 1'b0);
      applyStimulus(1'b1, 8'd77, 28'h0, 1'b0);
      applyStimulus(1'b0, 8'd255, 28'h1 << 26, 1'b0);
      applyStimulus(1'b1, 8'd130, 28'h7FFFFFC, 1'b0);
      applyStimulus(1'b0, 8'd27, 28'h0000001, 1'b0);
      applyStimulus(1'b0, 8'd26, 28'h0000001, 1'b0);
      drain();

      $display("[TB] backpressure");
      out_ready = 1'b0;
      firstExp  = refModel(1'b0, 8'd100, 28'h5000000);
      applyStimulus(1'b0, 8'd100, 28'h5000000, 1'b0);
      applyStimulus(1'b1, 8'd120, 28'h0123456, 1'b0);
      applyStimulus(1'b0, 8'd140, 28'hA00000F, 1'b0);
      in_sign  = 1'b1;
      in_exp   = 8'd90;
      in_mant  = 28'h3FFFFFF;
      in_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk);
         #1;
         checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
         checkOutput("stall_hold", 64'({out_valid, out_of, out_uf, out_result}),
                     64'({1'b1, firstExp}));
      end
      out_ready = 1'b1;
      applyStimulus(1'b1, 8'd90, 28'h3FFFFFF, 1'b0);
      applyStimulus(1'b0, 8'd200, 28'h0000800, 1'b0);
      applyStimulus(1'b1, 8'd250, 28'h8000001, 1'b0);
      drain();

      $display("[TB] reset with beats in flight");
      applyStimulus(1'b0, 8'd127, 28'h1 << 26, 1'b0);
      applyStimulus(1'b0, 8'd128, 28'h1 << 25, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_flight_valid", 64'(out_valid), 64'd0);
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         #1;
         checkOutput("no_stale_out", 64'(out_valid), 64'd0);
      end

      $display("[TB] random stream");
      for (int n = 0; n < 40; n++) begin
         rm = 28'($urandom) >> $urandom_range(0, 27);
         applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rm, 1'b1);
      end
      drain();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle_end", 64'(out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Single-precision post-arithmetic stage, directly downstream of the mantissa alignment shifter and the add/sub datapath.
- Takes the raw sign, 8-bit exponent and 28-bit extended mantissa. Normalises, rounds to nearest-even, and packs an IEEE-754 word with overflow/underflow flags.
- 3-stage pipeline, valid/ready on both sides, throughput 1 result/cycle.

Parameters:
- EXP_W, 8, exponent width.
- MANT_W, 28, extended mantissa width: [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S.
- ROUND_EN, 1, 1 = round-to-nearest-even; 0 = truncate (G/R/S dropped).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage accepts a beat this cycle.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  biased exponent of in_mant.
- in_mant  in  MANT_W  extended mantissa.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  packed IEEE-754 single.
- out_of  out  1  overflow, result forced to infinity.
- out_uf  out  1  underflow, result flushed to zero.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all stage valids, out_valid, out_result, out_of and out_uf go to 0. Beats in flight are discarded, with no partial output.
- Flow control: advance = !out_valid || out_ready; in_ready = advance. All three stages shift together when advance=1 and hold otherwise. A beat is accepted when in_valid && in_ready. Latency is exactly 3 cycles with no stall; bubbles propagate as invalid stages.
- While out_valid=1 && out_ready=0, out_result and the flags stay stable.
- S1 (detect):
  - mant[27]=1: right-shift 1, S |= shifted-out bit, exp+1.
  - mant=0: zero-class.
  - Otherwise lz = leading zeros counted from bit 26 (0..26).
  - Register the intermediate exponent EXP_W+2 bits wide, signed, to avoid wrap.
- S2 (normalise):
  - Left-shift by lz, exp_i = exp - lz. Shifted-in LSBs are 0 and S is preserved.
  - exp_i < 1 and not zero-class: uf=1, flush to signed zero.
- S3 (round/pack):
  - With ROUND_EN=1, round up when G && (R || S || mant[3]). Increment at bit 3.
  - Carry into bit 27 after increment: shift right 1, exp_i+1.
  - exp_i >= 255 (before or after rounding): of=1, result = {sign, 8'hFF, 23'h0}.
  - Otherwise result = {sign, exp_i[7:0], mant[25:3]}.
  - Zero-class: result = {sign, 31'h0}, both flags 0.
- In_exp = 255 input is not treated as NaN. It normalises like any exponent and ends as overflow.
- of and uf are never both 1.
- Denormal outputs are never produced.

Decomposition:
- Package fp_pkg holds:
  - Constants EXP_BIAS=127, EXP_MAX=255, bit positions CARRY_BIT=27, HIDDEN_BIT=26, G_BIT=2, R_BIT=1, S_BIT=0.
  - Packed struct fp32_t {sign, exp[7:0], frac[22:0]}.
  - Struct for the pipeline payload {sign, exp_i, mant, lz, zero, uf}.
- One sub-module: lzc28, a combinational leading-zero counter on bits [26:0] with zero flag. It is reused by the multiplier path.

Test Plan:
- Pass-through: exp=127, mant=1<<26 -> 0x3F800000 after 3 cycles, of=uf=0.
- Carry: exp=127, mant=0xC000000 -> 0x40400000 (3.0).
- Cancellation: exp=127, mant=1<<23 -> lz=3, result 0x3E000000 (0.125).
- RNE tie: exp=127, mant=(1<<26)|4 -> 0x3F800000. exp=127, mant=(1<<26)|(1<<3)|4 -> 0x3F800002.
- Boundaries:
  - exp=254, mant=0xC000000 -> 0x7F800000, of=1.
  - exp=2, mant=1<<20 -> 0x00000000, uf=1.
  - mant=0, sign=1 -> 0x80000000.
- Backpressure/reset:
  - Stream 6 beats with out_ready held 0 for 5 cycles: in_ready=0 while out_valid=1. All 6 results appear in order, none lost or duplicated.
  - Assert rst with 2 beats in flight: out_valid=0 the next cycle and no stale result afterward.
